// File: rtl/handshake_rr_arbiter.sv
// Round-robin arbiter sharing one 4-phase req/ack sender link among NREQ sclk-domain sources.
// The granted word is latched onto data_sout and held for the full req/ack cycle.
module handshake_rr_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 4,
  parameter int unsigned IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  sclk,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       src_valid,
  input  logic [NREQ*WIDTH-1:0] src_data,
  output logic [NREQ-1:0]       src_ready,
  input  logic                  ack,
  output logic                  req,
  output logic [WIDTH-1:0]      data_sout,
  output logic [IDW-1:0]        id_out,
  output logic                  busy
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SEND     = 2'd1,
    ST_WAIT_LOW = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_ack1;
  logic              r_ack_s;
  logic [IDW-1:0]    r_ptr;
  logic [IDW-1:0]    w_ptr_nxt;
  logic              r_req;
  logic              w_req_nxt;
  logic [WIDTH-1:0]  r_data;
  logic [WIDTH-1:0]  w_data_nxt;
  logic [IDW-1:0]    r_id;
  logic [IDW-1:0]    w_id_nxt;
  logic [NREQ-1:0]   r_src_ready;
  logic [NREQ-1:0]   w_src_ready_nxt;
  logic              r_busy;
  logic              w_busy_nxt;

  logic [WIDTH-1:0]  w_words [NREQ];
  logic [IDW-1:0]    w_scan;
  logic              w_gnt_vld;
  logic [IDW-1:0]    w_gnt_idx;

  // Unpack the flat source bus into per-source words.
  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_words[i] = src_data[i*WIDTH +: WIDTH];
    end
  end

  // First valid source scanning from the round-robin pointer upward, modulo NREQ.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_scan    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_scan = IDW'((32'(r_ptr) + k) % NREQ);
      if (!w_gnt_vld && src_valid[w_scan]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = w_scan;
      end
    end
  end

  // Next-state and next-output logic; all outputs are registered below.
  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_req_nxt       = r_req;
    w_data_nxt      = r_data;
    w_id_nxt        = r_id;
    w_src_ready_nxt = '0;
    case (r_state)
      ST_IDLE: begin
        w_req_nxt = 1'b0;
        // A stale-high synchronised ack blocks new grants until the receiver is idle.
        if (w_gnt_vld && !r_ack_s) begin
          w_data_nxt                 = w_words[w_gnt_idx];
          w_id_nxt                   = w_gnt_idx;
          w_req_nxt                  = 1'b1;
          w_src_ready_nxt[w_gnt_idx] = 1'b1;
          w_ptr_nxt                  = IDW'((32'(w_gnt_idx) + 1) % NREQ);
          w_state_nxt                = ST_SEND;
        end
      end
      ST_SEND: begin
        if (r_ack_s) begin
          w_req_nxt   = 1'b0;
          w_state_nxt = ST_WAIT_LOW;
        end
      end
      ST_WAIT_LOW: begin
        if (!r_ack_s) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_req_nxt   = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  // State, pointer, ack synchroniser and output registers.
  always_ff @(posedge sclk) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_ack1      <= 1'b0;
      r_ack_s     <= 1'b0;
      r_req       <= 1'b0;
      r_data      <= '0;
      r_id        <= '0;
      r_src_ready <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_ack1      <= ack;
      r_ack_s     <= r_ack1;
      r_req       <= w_req_nxt;
      r_data      <= w_data_nxt;
      r_id        <= w_id_nxt;
      r_src_ready <= w_src_ready_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  assign src_ready = r_src_ready;
  assign req       = r_req;
  assign data_sout = r_data;
  assign id_out    = r_id;
  assign busy      = r_busy;

endmodule
